// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART transmitter among
// NUM_REQ byte-stream requesters. An owner keeps the grant for a whole
// message, which ends with a byte flagged `last`. The arbiter issues one
// start pulse per byte and waits for the UART's done pulse before it
// sequences the next byte.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN. When it is defined, an
// idle-grant watchdog releases an owner that leaves req low for TIMEOUT
// cycles while in SEND.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick the next requester after ptr
// SEND  | owner holds grant; hand its byte over once UART is free
// WAIT  | byte handed over; wait for uart_tx_done

module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [8*NUM_REQ-1:0]   i_data,
    input  logic [NUM_REQ-1:0]     i_last,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_uart_tx_start,
    output logic [7:0]             o_uart_tx_data,
    input  logic                   i_uart_tx_busy,
    input  logic                   i_uart_tx_done,
    output logic                   o_active
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [NUM_REQ-1:0] r_grant, w_grant;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic [PW-1:0]      r_ptr, w_ptr;
    logic [PW-1:0]      r_own, w_own;
    logic               r_eom, w_eom;
    logic               r_start, w_start;
    logic [7:0]         r_data, w_data;
    logic               r_active;

    logic               w_req_g;
    logic               w_last_g;
    logic [7:0]         w_byte_g;
    logic               w_found;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]      r_wdog, w_wdog;
`endif

    // Pick out the current owner's req/last/byte.
    always_comb begin
        w_req_g  = 1'b0;
        w_last_g = 1'b0;
        w_byte_g = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_own == PW'(i)) begin
                w_req_g  = i_req[i];
                w_last_g = i_last[i];
                w_byte_g = i_data[8*i +: 8];
            end
        end
    end

    // Round-robin scan: first set req bit starting just after ptr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_ptr   = r_ptr;
        w_own   = r_own;
        w_eom   = r_eom;
        w_data  = r_data;
        w_ack   = '0;
        w_start = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_wdog  = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant = NUM_REQ'(1) << w_sel;
                    w_own   = w_sel;
                    w_state = S_SEND;
                end
            end
            S_SEND: begin
                if (w_req_g && !i_uart_tx_busy) begin
                    w_data  = w_byte_g;
                    w_start = 1'b1;
                    w_ack   = NUM_REQ'(1) << r_own;
                    w_eom   = w_last_g;
                    w_state = S_WAIT;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!w_req_g) begin
                    if (r_wdog == TW'(TIMEOUT - 1)) begin
                        w_grant = '0;
                        w_ptr   = r_own;
                        w_state = S_IDLE;
                    end else begin
                        w_wdog = r_wdog + 1'b1;
                    end
                end
`endif
            end
            S_WAIT: begin
                if (i_uart_tx_done) begin
                    if (r_eom) begin
                        w_grant = '0;
                        w_ptr   = r_own;
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_SEND;
                    end
                end
            end
            default: begin
                w_grant = '0;
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_ack    <= '0;
            r_ptr    <= PW'(NUM_REQ - 1);
            r_own    <= '0;
            r_eom    <= 1'b0;
            r_start  <= 1'b0;
            r_data   <= 8'h00;
            r_active <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_grant  <= w_grant;
            r_ack    <= w_ack;
            r_ptr    <= w_ptr;
            r_own    <= w_own;
            r_eom    <= w_eom;
            r_start  <= w_start;
            r_data   <= w_data;
            r_active <= |w_grant;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog   <= w_wdog;
`endif
        end
    end

    assign o_grant         = r_grant;
    assign o_ack           = r_ack;
    assign o_uart_tx_start = r_start;
    assign o_uart_tx_data  = r_data;
    assign o_active        = r_active;

endmodule
